stream_demux: RTL and testbench



---
 rtl/stream_demux.sv | 138 +++++++++++++
 tb/tb_stream_demux.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// Registered 1-to-N valid/ready demultiplexer with per-packet routing lock,
// broadcast, and a saturating counter for beats sent to non-existent channels.
module stream_demux #(
  parameter int data_bits = 8,
  parameter int sel_bits  = 2,
  parameter int num_ch    = 3,
  parameter int cnt_bits  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [data_bits-1:0]                 in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 in_last,
  input  logic [sel_bits-1:0]                  in_sel,
  input  logic                                 in_bcast,
  output logic [num_ch-1:0][data_bits-1:0]     out_data,
  output logic [num_ch-1:0]                    out_last,
  output logic [num_ch-1:0]                    out_valid,
  input  logic [num_ch-1:0]                    out_ready,
  output logic [cnt_bits-1:0]                  drop_cnt,
  output logic                                 busy
);

  typedef enum logic {S_IDLE, S_PKT} state_t;

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [sel_bits-1:0]               r_sel;
  logic                              r_bcast;
  logic [num_ch-1:0][data_bits-1:0]  r_data;
  logic [num_ch-1:0]                 r_last;
  logic [num_ch-1:0]                 r_valid;
  logic [cnt_bits-1:0]               r_drop;

  logic [sel_bits-1:0]               w_sel;
  logic                              w_bcast;
  logic                              w_sel_ok;
  logic [num_ch-1:0]                 w_free;
  logic [num_ch-1:0]                 w_hit;
  logic [num_ch-1:0]                 w_write;
  logic                              w_accept;
  logic                              w_drop;

  // Inside a packet the routing comes from the first beat, not the live inputs.
  assign w_sel    = (r_state == S_PKT) ? r_sel   : in_sel;
  assign w_bcast  = (r_state == S_PKT) ? r_bcast : in_bcast;
  assign w_sel_ok = int'(w_sel) < num_ch;

  // A slot can take a beat if it is empty or is being drained this cycle.
  assign w_free = ~r_valid | out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_hit = '0;
    for (int ch = 0; ch < num_ch; ch++) begin
      w_hit[ch] = w_bcast || (int'(w_sel) == ch);
    end
  end

  always_comb begin
    in_ready = 1'b1;
    if (w_bcast) begin
      in_ready = &w_free;
    end else if (w_sel_ok) begin
      in_ready = |(w_hit & w_free);
    end
  end

  assign w_accept = in_valid & in_ready;
  assign w_write  = {num_ch{w_accept}} & w_hit;
  assign w_drop   = w_accept & ~w_bcast & ~w_sel_ok;

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      if (in_last) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_state_nxt = S_PKT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel   <= '0;
      r_bcast <= 1'b0;
    end else if (w_accept && !in_last && r_state == S_IDLE) begin
      r_sel   <= in_sel;
      r_bcast <= in_bcast;
    end
  end

  // Output slots: a write wins over a drain, giving one beat per cycle per channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_last  <= '0;
      r_valid <= '0;
    end else begin
      for (int ch = 0; ch < num_ch; ch++) begin
        if (w_write[ch]) begin
          r_data[ch]  <= in_data;
          r_last[ch]  <= in_last;
          r_valid[ch] <= 1'b1;
        end else if (out_ready[ch]) begin
          r_valid[ch] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (w_drop && r_drop != '1) begin
      r_drop <= r_drop + 1'b1;
    end
  end

  assign out_data  = r_data;
  assign out_last  = r_last;
  assign out_valid = r_valid;
  assign drop_cnt  = r_drop;
  assign busy      = (r_state == S_PKT);

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench: directed scenarios plus random traffic, compared against
// per-channel expected-beat queues and a packet-level routing model.
module tb_stream_demux;

  localparam int DB = 8;
  localparam int SB = 2;
  localparam int NC = 3;
  localparam int CB = 8;
  localparam int DROP_MAX = (1 << CB) - 1;

  logic                      clk;
  logic                      rst_n;
  logic [DB-1:0]             in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_last;
  logic [SB-1:0]             in_sel;
  logic                      in_bcast;
  logic [NC-1:0][DB-1:0]     out_data;
  logic [NC-1:0]             out_last;
  logic [NC-1:0]             out_valid;
  logic [NC-1:0]             out_ready;
  logic [CB-1:0]             drop_cnt;
  logic                      busy;

  stream_demux #(.data_bits(DB), .sel_bits(SB), .num_ch(NC), .cnt_bits(CB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: what each channel still owes downstream, plus packet routing.
  typedef struct packed {
    logic [DB-1:0] d;
    logic          l;
  } beat_t;

  beat_t     exp_q[NC][$];
  int        m_drop = 0;
  bit        m_open = 0;
  int        m_sel = 0;
  bit        m_bcast = 0;

  // Called at a falling edge: drive inputs, compare outputs, advance model, clock once.
  task automatic step(input bit rst, input bit v, input logic [DB-1:0] d, input bit l,
                      input int s, input bit b, input logic [NC-1:0] rdy, output bit acc);
    int  esel;
    bit  ebc;
    bit  exp_rdy;
    bit  occ[NC];
    rst_n     = !rst;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    in_sel    = SB'(s);
    in_bcast  = b;
    out_ready = rdy;
    #1;
    esel = m_open ? m_sel : s;
    ebc  = m_open ? m_bcast : b;
    for (int ch = 0; ch < NC; ch++) occ[ch] = exp_q[ch].size() != 0;
    if (ebc) begin
      exp_rdy = 1;
      for (int ch = 0; ch < NC; ch++) if (occ[ch] && !rdy[ch]) exp_rdy = 0;
    end else if (esel < NC) begin
      exp_rdy = !occ[esel] || rdy[esel];
    end else begin
      exp_rdy = 1;
    end
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    for (int ch = 0; ch < NC; ch++) begin
      check($sformatf("out_valid[%0d]", ch), 32'(out_valid[ch]), 32'(occ[ch]));
      if (occ[ch] && out_valid[ch]) begin
        check($sformatf("out_data[%0d]", ch), 32'(out_data[ch]), 32'(exp_q[ch][0].d));
        check($sformatf("out_last[%0d]", ch), 32'(out_last[ch]), 32'(exp_q[ch][0].l));
      end
    end
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("busy", 32'(busy), 32'(m_open));

    acc = !rst && v && exp_rdy;
    if (rst) begin
      for (int ch = 0; ch < NC; ch++) exp_q[ch].delete();
      m_drop  = 0;
      m_open  = 0;
      m_sel   = 0;
      m_bcast = 0;
    end else begin
      for (int ch = 0; ch < NC; ch++) if (occ[ch] && rdy[ch]) void'(exp_q[ch].pop_front());
      if (acc) begin
        if (ebc) begin
          for (int ch = 0; ch < NC; ch++) exp_q[ch].push_back('{d: d, l: l});
        end else if (esel < NC) begin
          exp_q[esel].push_back('{d: d, l: l});
        end else if (m_drop < DROP_MAX) begin
          m_drop++;
        end
        if (l) begin
          m_open = 0;
        end else if (!m_open) begin
          m_open  = 1;
          m_sel   = s;
          m_bcast = b;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer one beat until accepted; out_ready follows rdy_hold for the first n_hold tries.
  task automatic send(input logic [DB-1:0] d, input bit l, input int s, input bit b,
                      input logic [NC-1:0] rdy_hold, input int n_hold,
                      input logic [NC-1:0] rdy_after);
    bit acc;
    int tries;
    tries = 0;
    acc   = 0;
    while (!acc && tries < 50) begin
      step(0, 1, d, l, s, b, (tries < n_hold) ? rdy_hold : rdy_after, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 32'(tries), 32'(0));
  endtask

  task automatic idle(input int n, input logic [NC-1:0] rdy);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0, rdy, acc);
  endtask

  initial begin
    bit acc;
    rst_n = 0; in_valid = 0; in_data = '0; in_last = 0; in_sel = '0; in_bcast = 0;
    out_ready = '0;
    @(negedge clk);
    step(1, 0, '0, 0, 0, 0, '0, acc);
    step(1, 0, '0, 0, 0, 0, '0, acc);
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    idle(1, 3'b111);

    // Single-beat unicast beats.
    send(8'h11, 1, 0, 0, 3'b111, 0, 3'b111);
    send(8'h22, 1, 1, 0, 3'b111, 0, 3'b111);
    send(8'h33, 1, 2, 0, 3'b111, 0, 3'b111);
    send(8'h44, 1, 0, 0, 3'b111, 0, 3'b111);
    idle(2, 3'b111);

    // Packet locked to channel 1 although in_sel moves to 2.
    send(8'hA0, 0, 1, 0, 3'b111, 0, 3'b111);
    send(8'hA1, 0, 2, 0, 3'b111, 0, 3'b111);
    send(8'hA2, 1, 2, 1, 3'b111, 0, 3'b111);
    idle(2, 3'b111);

    // Backpressure on channel 0 for 5 cycles.
    send(8'hB0, 1, 0, 0, 3'b000, 1, 3'b000);
    send(8'hB1, 1, 0, 0, 3'b000, 5, 3'b111);
    send(8'hB2, 1, 0, 0, 3'b111, 0, 3'b111);
    send(8'hB3, 1, 0, 0, 3'b111, 0, 3'b111);
    idle(2, 3'b111);

    // Broadcast, then a second broadcast stalls until channel 2 drains.
    send(8'h5A, 1, 0, 1, 3'b011, 0, 3'b011);
    send(8'h5B, 1, 0, 1, 3'b011, 3, 3'b111);
    idle(2, 3'b111);

    // Dropped 2-beat packet, then drops past saturation.
    send(8'hD0, 0, 3, 0, 3'b111, 0, 3'b111);
    send(8'hD1, 1, 0, 0, 3'b111, 0, 3'b111);
    for (int i = 0; i < 300; i++) send(DB'(i), 1, 3, 0, 3'b111, 0, 3'b111);
    idle(2, 3'b111);

    // Reset mid-packet with every slot full.
    send(8'hC0, 1, 0, 0, 3'b000, 1, 3'b000);
    send(8'hC2, 1, 2, 0, 3'b000, 1, 3'b000);
    send(8'hC1, 0, 1, 0, 3'b000, 1, 3'b000);
    idle(1, 3'b000);
    step(1, 0, '0, 0, 0, 0, 3'b000, acc);
    idle(1, 3'b000);
    send(8'hE2, 1, 2, 0, 3'b111, 0, 3'b111);
    idle(2, 3'b111);

    // Random traffic, including drops, broadcasts and stalls.
    for (int i = 0; i < 600; i++) begin
      step(0, $urandom_range(0, 3) != 0, DB'($urandom), $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, NC'($urandom), acc);
    end
    idle(4, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
